// File: rtl/gemm_result_drain_if.sv
// Store-port bundle between the result drain engine and the interface mux.
// Master drives a beat and holds it until the slave raises wr_ready.
interface gemm_result_drain_if #(
    parameter int unsigned DIM = 4,
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [DIM*DW-1:0] wr_data;
    logic [DIM-1:0]    wr_strb;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_strb,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_strb,
        output wr_ready
    );
endinterface

// File: rtl/gemm_result_drain.sv
// Drains one msize x nsize result tile from NBUF column-block accumulator banks to the
// store port, row-major, one DIM-element beat per bank per row.
module gemm_result_drain #(
    parameter int unsigned DIM  = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned NBUF = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned MW   = 8,
    localparam int unsigned NW  = $clog2(NBUF * DIM) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [MW-1:0]          msize,
    input  logic [NW-1:0]          nsize,
    input  logic [AW-1:0]          tile_c_addr,
    input  logic [AW-1:0]          c_stride,
    input  logic [NBUF-1:0]        acc_empty,
    input  logic [NBUF*DIM*DW-1:0] acc_rd_data,
    output logic [NBUF-1:0]        acc_rd_en,
    gemm_result_drain_if.master    wr,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam int unsigned BW       = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int unsigned BlkBytes = DIM * DW / 8;

    typedef enum logic [1:0] {StIdle, StWait, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [MW-1:0]     msize_q, msize_d;
    logic [NW-1:0]     nsize_q, nsize_d;
    logic [NW-1:0]     nb_q, nb_d;
    logic [AW-1:0]     stride_q, stride_d;
    logic [AW-1:0]     row_addr_q, row_addr_d;
    logic [MW-1:0]     r_q, r_d;
    logic [BW-1:0]     b_q, b_d;
    logic              wr_valid_q, wr_valid_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DIM*DW-1:0] wr_data_q, wr_data_d;
    logic [DIM-1:0]    wr_strb_q, wr_strb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic [DIM*DW-1:0] bank_row [NBUF];
    logic              cfg_ok;
    logic              last_b, last_r;
    logic [BW-1:0]     b_nxt;
    logic [MW-1:0]     r_nxt;
    logic [AW-1:0]     row_nxt;
    logic              ld_en;
    logic [BW-1:0]     ld_b;
    logic [AW-1:0]     ld_row;

    // Element e of a beat is valid while its column index is below nsize.
    function automatic logic [DIM-1:0] strb_for(logic [BW-1:0] bb, logic [NW-1:0] ns);
        logic [NW:0]    rem;
        logic [DIM-1:0] s;
        rem = {1'b0, ns} - (NW + 1)'(bb) * (NW + 1)'(DIM);
        for (int e = 0; e < DIM; e++) begin
            s[e] = ((NW + 1)'(e) < rem);
        end
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < NBUF; i++) begin
            bank_row[i] = acc_rd_data[i*DIM*DW +: DIM*DW];
        end
    end

    always_comb begin
        cfg_ok  = (msize != '0) && (nsize != '0) && (nsize <= NW'(NBUF * DIM));
        last_b  = (NW'(b_q) == nb_q - NW'(1));
        last_r  = (r_q == msize_q - MW'(1));
        b_nxt   = last_b ? '0 : b_q + BW'(1);
        r_nxt   = last_b ? r_q + MW'(1) : r_q;
        row_nxt = last_b ? row_addr_q + stride_q : row_addr_q;
    end

    always_comb begin
        state_d    = state_q;
        msize_d    = msize_q;
        nsize_d    = nsize_q;
        nb_d       = nb_q;
        stride_d   = stride_q;
        row_addr_d = row_addr_q;
        r_d        = r_q;
        b_d        = b_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        cfg_err_d  = 1'b0;
        ld_en      = 1'b0;
        ld_b       = b_q;
        ld_row     = row_addr_q;
        acc_rd_en  = '0;

        // abort outranks both start and wr_ready, so it is decoded first.
        if (abort) begin
            if (state_q != StIdle) begin
                state_d    = StIdle;
                wr_valid_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_ok) begin
                            msize_d    = msize;
                            nsize_d    = nsize;
                            nb_d       = NW'(({1'b0, nsize} + (NW + 1)'(DIM - 1))
                                             / (NW + 1)'(DIM));
                            stride_d   = c_stride;
                            row_addr_d = tile_c_addr;
                            r_d        = '0;
                            b_d        = '0;
                            state_d    = StWait;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (!acc_empty[b_q]) begin
                        ld_en      = 1'b1;
                        wr_valid_d = 1'b1;
                        state_d    = StWrite;
                    end
                end
                StWrite: begin
                    if (wr.wr_ready) begin
                        b_d        = b_nxt;
                        r_d        = r_nxt;
                        row_addr_d = row_nxt;
                        if (last_b && last_r) begin
                            wr_valid_d = 1'b0;
                            state_d    = StDone;
                        end else if (!acc_empty[b_nxt]) begin
                            ld_en  = 1'b1;
                            ld_b   = b_nxt;
                            ld_row = row_nxt;
                        end else begin
                            wr_valid_d = 1'b0;
                            state_d    = StWait;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (ld_en) begin
            acc_rd_en[ld_b] = 1'b1;
            wr_data_d       = bank_row[ld_b];
            wr_addr_d       = ld_row + AW'(ld_b) * AW'(BlkBytes);
            wr_strb_d       = strb_for(ld_b, nsize_q);
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            msize_q    <= '0;
            nsize_q    <= '0;
            nb_q       <= '0;
            stride_q   <= '0;
            row_addr_q <= '0;
            r_q        <= '0;
            b_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            msize_q    <= msize_d;
            nsize_q    <= nsize_d;
            nb_q       <= nb_d;
            stride_q   <= stride_d;
            row_addr_q <= row_addr_d;
            r_q        <= r_d;
            b_q        <= b_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign wr.wr_strb  = wr_strb_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule
